// File: rtl/forward_kinematics.sv
// SCARA forward kinematics: (th1, th2, l1, l2) -> (xPos, yPos).
// One iterative CORDIC rotator is used twice per request: first for link 1 at th1,
// then for link 2 at th1+th2; the two rotated vectors are summed, rounded and clamped.
// Optional joint-2 limit flag is built when FWDKIN_LIMIT_CHECK_EN is defined.
module forward_kinematics #(
  parameter int unsigned ITER    = 12,   // CORDIC iterations per rotation (<= 16)
  parameter int unsigned FRAC    = 8,    // fractional bits in the x/y datapath (1..16)
  parameter int unsigned TH2_MAX = 3800  // |th2| limit, angle LSBs
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [12:0] th1,
  input  logic signed [12:0] th2,
  input  logic        [13:0] l1,
  input  logic        [13:0] l2,
  output logic               busy,
  output logic               dataReady,
  output logic signed [15:0] xPos,
  output logic signed [15:0] yPos,
  output logic               limitFault
);

  localparam int unsigned W  = 14 + FRAC + 3;  // link length + fraction + CORDIC growth/sign
  localparam int unsigned SH = 16 - FRAC;       // rescale of the 1/K product
  localparam logic [3:0] LastIt = 4'(ITER - 1);
  localparam logic signed [W:0] Half   = (W + 1)'(1) << (FRAC - 1);
  localparam logic signed [W:0] PosMax = (W + 1)'(32767);
  localparam logic signed [W:0] PosMin = -(W + 1)'(32767);

`ifdef FWDKIN_LIMIT_CHECK_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRot1, StRot2, StSum, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic signed [W-1:0]   x_q, x_d, y_q, y_d;
  logic signed [W-1:0]   x1_q, x1_d, y1_q, y1_d;
  logic signed [15:0]    z_q, z_d;
  logic [13:0]           l2_q, l2_d;
  logic signed [12:0]    phi2_q, phi2_d, th2_q, th2_d;
  logic signed [15:0]    xpos_q, xpos_d, ypos_q, ypos_d;
  logic                  limit_q, limit_d;

  logic signed [W-1:0]   xs, ys, xn, yn;
  logic signed [15:0]    zn;
  logic [16:0]           pre1, pre2;
  logic signed [W:0]     sx, sy, rx, ry;
  logic signed [13:0]    th2_ext;
  logic [13:0]           th2_abs;

  // Start vector (l/K, 0) at FRAC bits, optionally negated by the pre-rotation.
  function automatic logic signed [W-1:0] start_vec(input logic [13:0] l, input logic neg);
    logic signed [W-1:0] v;
    v = W'((32'(l) * 32'd39797) >> SH);
    return neg ? -v : v;
  endfunction

  // Fold the angle into [-pi/2, pi/2]; returns {negate, residual in pi/32768 LSBs}.
  function automatic logic [16:0] pre_rot(input logic signed [12:0] a);
    logic signed [15:0] w;
    logic               neg;
    w   = 16'(a);
    neg = 1'b0;
    if (w > 16'sd2048) begin
      w   = w - 16'sd4096;
      neg = 1'b1;
    end else if (w < -16'sd2048) begin
      w   = w + 16'sd4096;
      neg = 1'b1;
    end
    return {neg, w <<< 3};
  endfunction

  // round(atan(2^-i) * 32768 / pi)
  function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      4'd12:   return 16'sd3;
      4'd13:   return 16'sd1;
      4'd14:   return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] clamp16(input logic signed [W:0] v);
    if (v > PosMax) return 16'sd32767;
    if (v < PosMin) return -16'sd32767;
    return 16'(v);
  endfunction

  // One CORDIC micro-rotation, driving the residual angle towards zero.
  always_comb begin
    xs = x_q >>> cnt_q;
    ys = y_q >>> cnt_q;
    if (!z_q[15]) begin
      xn = x_q - ys;
      yn = y_q + xs;
      zn = z_q - atan_lut(cnt_q);
    end else begin
      xn = x_q + ys;
      yn = y_q - xs;
      zn = z_q + atan_lut(cnt_q);
    end
  end

  // Pre-rotation, final sum with round-half-up, and |th2| for the limit check.
  always_comb begin
    pre1    = pre_rot(th1);
    pre2    = pre_rot(phi2_q);
    sx      = (W + 1)'(x1_q) + (W + 1)'(x_q);
    sy      = (W + 1)'(y1_q) + (W + 1)'(y_q);
    rx      = (sx + Half) >>> FRAC;
    ry      = (sy + Half) >>> FRAC;
    th2_ext = 14'(th2_q);
    th2_abs = th2_ext[13] ? -th2_ext : th2_ext;
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    l2_d    = l2_q;
    phi2_d  = phi2_q;
    th2_d   = th2_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    limit_d = limit_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          x_d     = start_vec(l1, pre1[16]);
          y_d     = '0;
          z_d     = pre1[15:0];
          l2_d    = l2;
          phi2_d  = th1 + th2;  // wraps modulo 2^13
          th2_d   = th2;
          cnt_d   = '0;
          state_d = StRot1;
        end
      end
      StRot1: begin
        x_d   = xn;
        y_d   = yn;
        z_d   = zn;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastIt) begin
          // Park link-1 result and load the link-2 vector into the rotator.
          x1_d    = xn;
          y1_d    = yn;
          x_d     = start_vec(l2_q, pre2[16]);
          y_d     = '0;
          z_d     = pre2[15:0];
          cnt_d   = '0;
          state_d = StRot2;
        end
      end
      StRot2: begin
        x_d   = xn;
        y_d   = yn;
        z_d   = zn;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastIt) begin
          cnt_d   = '0;
          state_d = StSum;
        end
      end
      StSum: begin
        xpos_d  = clamp16(rx);
        ypos_d  = clamp16(ry);
        limit_d = LimitEn && (32'(th2_abs) > TH2_MAX);
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      l2_q    <= '0;
      phi2_q  <= '0;
      th2_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      l2_q    <= l2_d;
      phi2_q  <= phi2_d;
      th2_q   <= th2_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      limit_q <= limit_d;
    end
  end

  assign busy       = (state_q == StRot1) || (state_q == StRot2) || (state_q == StSum);
  assign dataReady  = (state_q == StDone);
  assign xPos       = xpos_q;
  assign yPos       = ypos_q;
  assign limitFault = limit_q;

endmodule
